// File: rtl/msdap_frame_rx.sv
// MSDAP serial front end: L/R deserialiser, word-pair FIFO, zero-run sleep/wake.
// Optional: define RX_FRAME_ERR_CNT_EN to add the saturating frame_err_cnt output.
module msdap_frame_rx #(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ZERO_RUN   = 800,
    parameter int ZCNT_W     = 10
) (
    input  logic                          dclk,
    input  logic                          reset_n,
    input  logic                          rx_en,
    input  logic                          frame,
    input  logic                          inputL,
    input  logic                          inputR,
    output logic                          word_valid,
    output logic [WORD_W-1:0]             word_L,
    output logic [WORD_W-1:0]             word_R,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err,
    output logic                          sleep,
    output logic                          wake
`ifdef RX_FRAME_ERR_CNT_EN
    ,
    output logic [7:0]                    frame_err_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(WORD_W);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]   shl_q, shl_d;
    logic [WORD_W-1:0]   shr_q, shr_d;
    logic                frame_err_q, frame_err_d;
    logic                push;

    logic [2*WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [2*WORD_W-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [2*WORD_W-1:0] head_q, head_d;
    logic                overflow_q, overflow_d;
    logic                pop, full, push_ok;

    logic [ZCNT_W-1:0]   zcnt_q, zcnt_d;
    logic                sleep_q, sleep_d;
    logic                wake_q, wake_d;

    // Words arrive LSB first, so shifting in from the top leaves bit 0 at the LSB.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shl_d       = shl_q;
        shr_d       = shr_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_en && frame) begin
                    shl_d     = {inputL, shl_q[WORD_W-1:1]};
                    shr_d     = {inputR, shr_q[WORD_W-1:1]};
                    bit_cnt_d = BW'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (!rx_en) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else begin
                    shl_d = {inputL, shl_q[WORD_W-1:1]};
                    shr_d = {inputR, shr_q[WORD_W-1:1]};
                    if (frame) begin
                        frame_err_d = 1'b1;
                        bit_cnt_d   = BW'(1);
                    end else if (bit_cnt_q == BW'(WORD_W - 1)) begin
                        push      = 1'b1;
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop frees the full slot on the same edge, so push+pop never drops.
    always_comb begin
        pop        = (count_q != '0) && word_ready;
        full       = (count_q == CW'(FIFO_DEPTH));
        push_ok    = push && (!full || pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push & ~push_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = {shl_d, shr_d};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        head_d = head_q;
        if (count_d != '0) begin
            head_d = mem_d[rd_ptr_d];
        end
    end

    always_comb begin
        zcnt_d  = zcnt_q;
        sleep_d = sleep_q;
        wake_d  = 1'b0;
        if (push) begin
            if (shl_d == '0 && shr_d == '0) begin
                if (zcnt_q != ZCNT_W'(ZERO_RUN)) begin
                    zcnt_d = zcnt_q + 1'b1;
                end
                if (zcnt_d == ZCNT_W'(ZERO_RUN)) begin
                    sleep_d = 1'b1;
                end
            end else begin
                zcnt_d  = '0;
                sleep_d = 1'b0;
                wake_d  = sleep_q;
            end
        end
    end

    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shl_q       <= '0;
            shr_q       <= '0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= '0;
            overflow_q  <= 1'b0;
            zcnt_q      <= '0;
            sleep_q     <= 1'b0;
            wake_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shl_q       <= shl_d;
            shr_q       <= shr_d;
            frame_err_q <= frame_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            overflow_q  <= overflow_d;
            zcnt_q      <= zcnt_d;
            sleep_q     <= sleep_d;
            wake_q      <= wake_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

`ifdef RX_FRAME_ERR_CNT_EN
    logic [7:0] fec_q, fec_d;

    always_comb begin
        fec_d = fec_q;
        if (frame_err_q && fec_q != 8'hFF) begin
            fec_d = fec_q + 1'b1;
        end
    end

    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            fec_q <= '0;
        end else begin
            fec_q <= fec_d;
        end
    end

    assign frame_err_cnt = fec_q;
`endif

    assign word_valid = (count_q != '0);
    assign word_L     = head_q[2*WORD_W-1:WORD_W];
    assign word_R     = head_q[WORD_W-1:0];
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;
    assign sleep      = sleep_q;
    assign wake       = wake_q;

endmodule
